// File: rtl/fp16_pkg.sv
// Shared binary16 encoding for the float16 adder front and back ends.
// Holds the one-hot operand class codes, the pair special-outcome codes, the exponent
// constants and the decoded-operand struct. The result packer uses the same encoding.
package fp16_pkg;

    // One-hot operand class
    localparam logic [5:0] FP_SNAN      = 6'b000001;
    localparam logic [5:0] FP_QNAN      = 6'b000010;
    localparam logic [5:0] FP_INF       = 6'b000100;
    localparam logic [5:0] FP_ZERO      = 6'b001000;
    localparam logic [5:0] FP_SUBNORMAL = 6'b010000;
    localparam logic [5:0] FP_NORMAL    = 6'b100000;

    // Special outcome of an operand pair
    localparam logic [2:0] EXTREME_NONE = 3'b000;
    localparam logic [2:0] EXTREME_SNAN = 3'b001;
    localparam logic [2:0] EXTREME_QNAN = 3'b010;
    localparam logic [2:0] EXTREME_INF  = 3'b100;

    localparam int FP16_BIAS        = 15;
    localparam int FP16_EMIN        = -14;
    // Exponent reported for NaN and infinity (all-ones biased exponent, unbiased)
    localparam int FP16_EXP_SPECIAL = 16;

    // exp is a 7-bit two's-complement unbiased exponent
    typedef struct packed {
        logic       sign;
        logic [6:0] exp;
        logic [10:0] sig;
        logic [5:0] cls;
    } fp16_dec_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational decode of one binary16 value into sign, unbiased exponent,
// significand with hidden bit, and one-hot class.
// Ports:
//   din  in  16  raw binary16 operand
//   dec  out     decoded fields (fp16_dec_t)
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [15:0] din,
    output fp16_dec_t   dec
);

    logic [4:0] e;
    logic [9:0] m;

    assign e = din[14:10];
    assign m = din[9:0];

    always_comb begin
        dec.sign = din[15];
        dec.exp  = 7'(FP16_EXP_SPECIAL);
        dec.sig  = {1'b1, m};
        dec.cls  = FP_INF;
        if (e == 5'h1f) begin
            // m[9] is the quiet bit; a zero fraction is infinity
            if (m == 10'd0) begin
                dec.cls = FP_INF;
            end else if (m[9]) begin
                dec.cls = FP_QNAN;
            end else begin
                dec.cls = FP_SNAN;
            end
        end else if (e == 5'd0) begin
            // Zero and subnormals share the minimum exponent and have no hidden bit
            dec.exp = 7'(FP16_EMIN);
            dec.sig = {1'b0, m};
            dec.cls = (m == 10'd0) ? FP_ZERO : FP_SUBNORMAL;
        end else begin
            dec.exp = {2'b00, e} - 7'(FP16_BIAS);
            dec.sig = {1'b1, m};
            dec.cls = FP_NORMAL;
        end
    end

endmodule

// File: rtl/operand_unpack.sv
// Input stage of the float16 adder. Two-stage valid/ready pipeline: S1 captures the raw
// operand pair, S2 captures the decoded fields, the pair's special-value outcome and the
// exponent difference for the aligner. Full backpressure, one pair per cycle.
// Ports:
//   CLK, RSTn            clock, asynchronous active-low reset
//   DVI, RDY, DIA, DIB   input pair handshake and binary16 operands
//   DVO, DS_RDY          output handshake
//   SIGN_x/EXP_x/SIG_x/TYPE_x  decoded operand A/B fields
//   EXTREME_TYPE/SIGN    pair special outcome for the packer
//   EXP_DIFF             signed EXP_A - EXP_B (0 when EN_EXP_DIFF = 0)
module operand_unpack
    import fp16_pkg::*;
#(
    parameter bit EN_EXP_DIFF = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        DVI,
    output logic        RDY,
    input  logic [15:0] DIA,
    input  logic [15:0] DIB,
    output logic        DVO,
    input  logic        DS_RDY,
    output logic        SIGN_A,
    output logic        SIGN_B,
    output logic [6:0]  EXP_A,
    output logic [6:0]  EXP_B,
    output logic [10:0] SIG_A,
    output logic [10:0] SIG_B,
    output logic [5:0]  TYPE_A,
    output logic [5:0]  TYPE_B,
    output logic [2:0]  EXTREME_TYPE,
    output logic        EXTREME_SIGN,
    output logic [6:0]  EXP_DIFF
);

    logic        s1_v;
    logic        s2_v;
    logic        s1_en;
    logic        s2_en;
    logic [15:0] s1_a;
    logic [15:0] s1_b;

    fp16_dec_t   dec_a;
    fp16_dec_t   dec_b;
    logic [2:0]  ext_type;
    logic        ext_sign;
    logic [6:0]  exp_diff;

    fp16_dec_t   s2_a;
    fp16_dec_t   s2_b;
    logic [2:0]  s2_ext_type;
    logic        s2_ext_sign;
    logic [6:0]  s2_exp_diff;

    // Ready depends only on pipeline state, never on DVI
    assign s2_en = !s2_v || DS_RDY;
    assign s1_en = !s1_v || s2_en;
    assign RDY   = s1_en;

    fp16_classify u_classify_a (
        .din (s1_a),
        .dec (dec_a)
    );

    fp16_classify u_classify_b (
        .din (s1_b),
        .dec (dec_b)
    );

    // Pair outcome: sNaN beats qNaN beats inf; opposite infinities make a positive qNaN
    always_comb begin
        logic snan_a, snan_b, qnan_a, qnan_b, inf_a, inf_b;
        snan_a   = (dec_a.cls == FP_SNAN);
        snan_b   = (dec_b.cls == FP_SNAN);
        qnan_a   = (dec_a.cls == FP_QNAN);
        qnan_b   = (dec_b.cls == FP_QNAN);
        inf_a    = (dec_a.cls == FP_INF);
        inf_b    = (dec_b.cls == FP_INF);
        ext_type = EXTREME_NONE;
        ext_sign = 1'b0;
        if (snan_a || snan_b) begin
            ext_type = EXTREME_SNAN;
            ext_sign = snan_a ? dec_a.sign : dec_b.sign;
        end else if (qnan_a || qnan_b) begin
            ext_type = EXTREME_QNAN;
            ext_sign = qnan_a ? dec_a.sign : dec_b.sign;
        end else if (inf_a && inf_b && (dec_a.sign != dec_b.sign)) begin
            ext_type = EXTREME_QNAN;
            ext_sign = 1'b0;
        end else if (inf_a || inf_b) begin
            ext_type = EXTREME_INF;
            ext_sign = inf_a ? dec_a.sign : dec_b.sign;
        end
    end

    // Wraps modulo 2^7; finite pairs stay within -30..30
    if (EN_EXP_DIFF) begin : g_exp_diff
        assign exp_diff = dec_a.exp - dec_b.exp;
    end else begin : g_no_exp_diff
        assign exp_diff = 7'd0;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            s1_v        <= 1'b0;
            s1_a        <= 16'd0;
            s1_b        <= 16'd0;
            s2_v        <= 1'b0;
            s2_a        <= '0;
            s2_b        <= '0;
            s2_ext_type <= 3'd0;
            s2_ext_sign <= 1'b0;
            s2_exp_diff <= 7'd0;
        end else begin
            if (s2_en) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_a        <= dec_a;
                    s2_b        <= dec_b;
                    s2_ext_type <= ext_type;
                    s2_ext_sign <= ext_sign;
                    s2_exp_diff <= exp_diff;
                end
            end
            if (s1_en) begin
                s1_v <= DVI;
                s1_a <= DIA;
                s1_b <= DIB;
            end
        end
    end

    assign DVO          = s2_v;
    assign SIGN_A       = s2_a.sign;
    assign SIGN_B       = s2_b.sign;
    assign EXP_A        = s2_a.exp;
    assign EXP_B        = s2_b.exp;
    assign SIG_A        = s2_a.sig;
    assign SIG_B        = s2_b.sig;
    assign TYPE_A       = s2_a.cls;
    assign TYPE_B       = s2_b.cls;
    assign EXTREME_TYPE = s2_ext_type;
    assign EXTREME_SIGN = s2_ext_sign;
    assign EXP_DIFF     = s2_exp_diff;

endmodule
